norm_adjust_p: RTL
==================

NORM_ADJUST_P -- requirements
Module: norm_adjust_p

Interface
REQ-001 SHALL have parameter MANT_W, 64, mantissa product width (>=8).
REQ-002 SHALL have parameter ES, 3, posit exponent field width.
REQ-003 SHALL have parameter EXP_W, 10, signed two's-complement width of scale in/out.
REQ-004 SHALL have parameter K_W, 6, signed regime width; ES+K_W <= EXP_W.
REQ-005 SHALL have parameter STEP, 8, maximum left-shift distance per cycle (1..MANT_W-2).
REQ-006 SHALL have port clk  input  1  single clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1; input handshake, transfer when both are high.
REQ-009 SHALL have ports E_raw input EXP_W, mant_prod input MANT_W and sign_in input 1; operands sampled on input transfer.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1; output handshake, transfer when both are high.
REQ-011 SHALL have ports mant_adj output MANT_W, adj_exp output ES, adj_k output K_W (signed), sign_out output 1; the normalised result.
REQ-012 SHALL have ports sticky output 1, zero output 1, ovf output 1, unf output 1 and shift_cnt output $clog2(MANT_W)+1; result flags and total shift distance.

Function
REQ-013 SHALL implement FSM IDLE -> SHIFT -> OUT -> IDLE; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-014 IDLE: on input transfer SHALL load mant_work=mant_prod, scale=sign-extended E_raw (EXP_W+1 bits, no wrap), sticky_w=0, cnt=0, latch sign_in, and go to SHIFT.
REQ-015 SHIFT, mant_work==0: SHALL set zero=1, mant_adj=0, adj_exp=0, adj_k=0, ovf=unf=0, and go to OUT.
REQ-016 SHIFT, top bits 1x: SHALL shift right 1, scale+1, cnt+1, sticky_w |= dropped LSB, and stay in SHIFT.
REQ-017 SHIFT, top bits 00: with lz = leading-zero count, SHALL shift left by d=min(lz-1, STEP), scale-d, cnt+d, and stay in SHIFT.
REQ-018 SHIFT, top bits 01: SHALL register the outputs in the same edge and go to OUT.
REQ-019 The SHIFT-to-OUT load SHALL set mant_adj=mant_work, sticky=sticky_w, shift_cnt=cnt, sign_out=latched sign, and zero=0.
REQ-020 Range is Smin=-(2^(K_W-1))*2^ES to Smax=2^(K_W-1)*2^ES-1; scale>Smax SHALL set ovf=1 and clamp to Smax; scale<Smin SHALL set unf=1 and clamp to Smin.
REQ-021 SHALL set adj_exp=clamped_scale[ES-1:0] and adj_k=clamped_scale[ES+K_W-1:ES].
REQ-022 Latency from input transfer to out_valid SHALL be 2 + number of shift cycles: one right shift, or ceil((lz-1)/STEP) left shifts; 01-aligned or zero input gives 2.
REQ-023 OUT: all outputs SHALL hold stable while out_ready=0; on output transfer SHALL go to IDLE, with in_ready=1 the next cycle (no same-cycle bypass).
REQ-024 in_valid in a non-IDLE state SHALL be ignored; output registers SHALL hold their last values outside OUT.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE and clear all outputs, flags, shift_cnt and internal registers, in_ready=0 during reset and 1 from the first post-reset cycle.
REQ-026 Reset mid-SHIFT or mid-OUT SHALL abandon the operation with no output transfer.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the default parameter constants (MANT_W, ES, EXP_W, K_W).
REQ-028 The leading-zero counter SHALL be a separate parametrised sub-module, lzc_p (input MANT_W bits, output count and all-zero).

Verification (defaults)
REQ-029 mant_prod=0x4000_0000_0000_0000, E_raw=19 -> out_valid 2 cycles after transfer; adj_exp=3, adj_k=2, shift_cnt=0, sticky=0.
REQ-030 mant_prod=0xC000_0000_0000_0001, E_raw=5 -> mant_adj=0x6000_0000_0000_0000, adj_exp=6, adj_k=0, sticky=1, shift_cnt=1, latency 3.
REQ-031 mant_prod=0x0000_0000_0000_0001, E_raw=100 -> mant_adj=0x4000_0000_0000_0000, adj_exp=6, adj_k=4, shift_cnt=62, latency 10.
REQ-032 mant_prod=0, any E_raw -> zero=1, mant_adj=0, latency 2, no hang.
REQ-033 mant_prod=0x8000_0000_0000_0000, E_raw=255 -> ovf=1, adj_exp=7, adj_k=31; repeat with 0x0000_0000_0000_0001, E_raw=-200 -> unf=1, adj_exp=0, adj_k=-32.
REQ-034 out_ready=0 for 5 cycles with in_valid held high -> outputs stable and in_ready=0 throughout; rst_n pulsed during SHIFT -> all outputs 0, IDLE, next operand processed correctly.

Source files
------------

// File: rtl/norm_adjust_p_pkg.sv
// Shared definitions for the posit normalisation/adjust block.
//   - default parameter constants for mantissa, exponent and regime widths
//   - FSM state encoding used by norm_adjust_p
package norm_adjust_p_pkg;

  localparam int unsigned MANT_W_D = 64;
  localparam int unsigned ES_D     = 3;
  localparam int unsigned EXP_W_D  = 10;
  localparam int unsigned K_W_D    = 6;
  localparam int unsigned STEP_D   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/lzc_p.sv
// Parametrised leading-zero counter.
//   data     : word to scan (MSB first)
//   cnt      : number of leading zeros (W when data is all zero)
//   all_zero : data == 0
module lzc_p #(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = $clog2(W) + 1
) (
  input  logic [W-1:0]     data,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (data[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/norm_adjust_p.sv
// Normalises a mantissa product to the 01.xxx form, tracks the scale, and
// splits the clamped scale into posit exponent and regime fields.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : operand handshake (E_raw, mant_prod, sign_in)
//   out_valid/out_ready           : result handshake
//   mant_adj, adj_exp, adj_k      : normalised mantissa, exponent field, signed regime
//   sign_out, sticky, zero        : latched sign, dropped-bit OR, zero-input flag
//   ovf, unf                      : scale clamped to max / min
//   shift_cnt                     : total shift distance applied
module norm_adjust_p
  import norm_adjust_p_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_D,
  parameter int unsigned ES     = ES_D,
  parameter int unsigned EXP_W  = EXP_W_D,
  parameter int unsigned K_W    = K_W_D,
  parameter int unsigned STEP   = STEP_D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [EXP_W-1:0]     E_raw,
  input  logic [MANT_W-1:0]           mant_prod,
  input  logic                        sign_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MANT_W-1:0]           mant_adj,
  output logic [ES-1:0]               adj_exp,
  output logic signed [K_W-1:0]       adj_k,
  output logic                        sign_out,
  output logic                        sticky,
  output logic                        zero,
  output logic                        ovf,
  output logic                        unf,
  output logic [$clog2(MANT_W):0]     shift_cnt
);

  localparam int unsigned CNT_W   = $clog2(MANT_W) + 1;
  localparam int unsigned SCALE_W = EXP_W + 1;
  localparam int unsigned CL_W    = ES + K_W;

  localparam int SMAX_I = (1 << (ES + K_W - 1)) - 1;
  localparam int SMIN_I = -(1 << (ES + K_W - 1));

  localparam logic signed [SCALE_W-1:0] SMAX_S = SCALE_W'(SMAX_I);
  localparam logic signed [SCALE_W-1:0] SMIN_S = SCALE_W'(SMIN_I);
  localparam logic [CL_W-1:0]           CL_MAX = CL_W'(SMAX_I);
  localparam logic [CL_W-1:0]           CL_MIN = CL_W'(SMIN_I);

  state_t                     state;
  logic [MANT_W-1:0]          mant_work;
  logic signed [SCALE_W-1:0]  scale;
  logic                       sticky_w;
  logic [CNT_W-1:0]           cnt;
  logic                       sign_l;

  logic [CNT_W-1:0]           lz;
  logic                       all_zero;
  logic [CNT_W-1:0]           lz_m1;
  logic [CNT_W-1:0]           d;
  logic                       ovf_c;
  logic                       unf_c;
  logic [CL_W-1:0]            clamped_c;

  lzc_p #(
    .W     (MANT_W),
    .CNT_W (CNT_W)
  ) u_lzc (
    .data     (mant_work),
    .cnt      (lz),
    .all_zero (all_zero)
  );

  // Left-shift distance leaves the leading one at MSB-1; clamp of the scale.
  always_comb begin
    lz_m1     = lz - CNT_W'(1);
    d         = (lz_m1 < CNT_W'(STEP)) ? lz_m1 : CNT_W'(STEP);
    ovf_c     = (scale > SMAX_S);
    unf_c     = (scale < SMIN_S);
    clamped_c = ovf_c ? CL_MAX : (unf_c ? CL_MIN : CL_W'(scale));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mant_work <= '0;
      scale     <= '0;
      sticky_w  <= 1'b0;
      cnt       <= '0;
      sign_l    <= 1'b0;
      mant_adj  <= '0;
      adj_exp   <= '0;
      adj_k     <= '0;
      sign_out  <= 1'b0;
      sticky    <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      shift_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mant_work <= mant_prod;
            scale     <= SCALE_W'(E_raw);
            sticky_w  <= 1'b0;
            cnt       <= '0;
            sign_l    <= sign_in;
            in_ready  <= 1'b0;
            state     <= ST_SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (all_zero) begin
            mant_adj  <= '0;
            adj_exp   <= '0;
            adj_k     <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            sticky    <= sticky_w;
            shift_cnt <= cnt;
            sign_out  <= sign_l;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (mant_work[MANT_W-1]) begin
            // Product overflowed into the top bit: one right shift.
            mant_work <= mant_work >> 1;
            sticky_w  <= sticky_w | mant_work[0];
            scale     <= scale + SCALE_W'(1);
            cnt       <= cnt + CNT_W'(1);
          end else if (!mant_work[MANT_W-2]) begin
            mant_work <= mant_work << d;
            scale     <= scale - $signed(SCALE_W'(d));
            cnt       <= cnt + d;
          end else begin
            mant_adj  <= mant_work;
            adj_exp   <= clamped_c[ES-1:0];
            adj_k     <= clamped_c[CL_W-1:ES];
            zero      <= 1'b0;
            ovf       <= ovf_c;
            unf       <= unf_c;
            sticky    <= sticky_w;
            shift_cnt <= cnt;
            sign_out  <= sign_l;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
